// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment hex display controller: shadow-latched value/dp/blink,
// leading-zero suppression, free-running blink, registered active-low outputs.
module hex_display_ctrl #(
  parameter int NDIGITS   = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blink_mask,
  input  logic                   lz_en,
  input  logic                   enable,
  output logic [7*NDIGITS-1:0]   seg,
  output logic [NDIGITS-1:0]     seg_dp,
  output logic                   busy
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [4*NDIGITS-1:0] value_q;
  logic [NDIGITS-1:0]   dp_q;
  logic [NDIGITS-1:0]   blink_q;
  logic                 busy_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [7*NDIGITS-1:0] seg_q, seg_d;
  logic [NDIGITS-1:0]   seg_dp_q, seg_dp_d;
  logic [NDIGITS-1:0]   keep;
  logic                 seen;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Blink counter restarts on load so a freshly loaded digit is visible a full half-period.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (load) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // A digit is kept if it or any higher digit is nonzero or has its decimal point lit.
  always_comb begin
    keep = '0;
    seen = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      seen    = seen | (value_q[4*i +: 4] != 4'h0) | dp_q[i];
      keep[i] = seen;
    end
    keep[0] = 1'b1;
  end

  always_comb begin
    seg_d    = '1;
    seg_dp_d = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (enable && !(phase_q && blink_q[i]) && !(lz_en && !keep[i])) begin
        seg_d[7*i +: 7] = seg7(value_q[4*i +: 4]);
        seg_dp_d[i]     = ~dp_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      dp_q     <= '0;
      blink_q  <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      seg_q    <= '1;
      seg_dp_q <= '1;
    end else begin
      if (load) begin
        value_q <= value;
        dp_q    <= dp;
        blink_q <= blink_mask;
      end
      busy_q   <= load;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl (4 digits, blink half-period of 4 cycles).
module tb_hex_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic        enable;
  logic [27:0] seg;
  logic [3:0]  seg_dp;
  logic        busy;

  hex_display_ctrl #(.NDIGITS(4), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp),
    .blink_mask(blink_mask), .lz_en(lz_en), .enable(enable),
    .seg(seg), .seg_dp(seg_dp), .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic [27:0] seg;
    logic [3:0]  dp;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_at(input int c, input logic [6:0] d3, input logic [6:0] d2,
                           input logic [6:0] d1, input logic [6:0] d0,
                           input logic [3:0] dpv, input logic b, input string nm);
    exp_t e;
    e.cyc  = c;
    e.seg  = {d3, d2, d1, d0};
    e.dp   = dpv;
    e.busy = b;
    e.name = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compares every expectation due at or before the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s missed: due cyc %0d, seen at cyc %0d", e.name, e.cyc, cyc);
        end else if (seg !== e.seg || seg_dp !== e.dp || busy !== e.busy) begin
          errors++;
          $display("FAIL %s cyc=%0d seg got %b want %b, seg_dp got %b want %b, busy got %b want %b",
                   e.name, cyc, seg, e.seg, seg_dp, e.dp, busy, e.busy);
        end
      end
    end
  end

  initial begin
    int c;
    int n;
    int budget;
    logic [6:0] d0;
    rst_n = 1'b1; load = 1'b0; value = '0; dp = '0; blink_mask = '0;
    lz_en = 1'b0; enable = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    expect_at(cyc, BL, BL, BL, BL, 4'hF, 1'b0, "reset_async");
    ->chk_ev;
    repeat (3) tick();

    // Release reset: shadow value 0 shows all zeros, then only digit 0 with lz_en
    rst_n = 1'b1;
    expect_at(cyc + 1, S0, S0, S0, S0, 4'hF, 1'b0, "post_reset_lz0");
    tick();
    lz_en = 1'b1;
    expect_at(cyc + 1, BL, BL, BL, S0, 4'hF, 1'b0, "post_reset_lz1");
    tick();

    // Plain decode of 12AF
    lz_en = 1'b0; value = 16'h12AF; load = 1'b1;
    expect_at(cyc + 1, S0, S0, S0, S0, 4'hF, 1'b1, "load_busy");
    expect_at(cyc + 2, S1, S2, SA, SF, 4'hF, 1'b0, "decode_12AF");
    tick(); load = 1'b0; tick();

    // Leading-zero suppression, then a decimal point holding a zero digit
    lz_en = 1'b1; value = 16'h0030; dp = 4'b0000; load = 1'b1;
    expect_at(cyc + 1, S1, S2, SA, SF, 4'hF, 1'b1, "lz_busy");
    expect_at(cyc + 2, BL, BL, S3, S0, 4'hF, 1'b0, "lz_0030");
    tick(); load = 1'b0; tick();
    dp = 4'b0100; load = 1'b1;
    expect_at(cyc + 1, BL, BL, S3, S0, 4'hF, 1'b1, "lz_dp_busy");
    expect_at(cyc + 2, BL, S0, S3, S0, 4'b1011, 1'b0, "lz_dp_0030");
    tick(); load = 1'b0; tick();

    // Back-to-back loads: last one wins
    lz_en = 1'b0; dp = 4'b0000; value = 16'h1111; load = 1'b1; c = cyc;
    expect_at(c + 1, S0, S0, S3, S0, 4'b1011, 1'b1, "b2b_first");
    expect_at(c + 2, S1, S1, S1, S1, 4'hF, 1'b1, "b2b_mid");
    expect_at(c + 3, S2, S2, S2, S2, 4'hF, 1'b0, "b2b_final");
    expect_at(c + 4, S2, S2, S2, S2, 4'hF, 1'b0, "b2b_hold");
    tick(); value = 16'h2222; tick(); load = 1'b0; tick(); tick();

    // Blinking digit 0 with an enable pulse in the middle of an off half-period
    value = 16'h0008; blink_mask = 4'b0001; load = 1'b1; n = cyc + 1;
    expect_at(n, S2, S2, S2, S2, 4'hF, 1'b1, "blink_busy");
    for (int j = 1; j <= 17; j++) begin
      d0 = (((j - 1) / 4) % 2 == 1) ? BL : S8;
      if (j == 14) expect_at(n + j, BL, BL, BL, BL, 4'hF, 1'b0, "enable_off");
      else         expect_at(n + j, S0, S0, S0, d0, 4'hF, 1'b0, "blink");
    end
    tick(); load = 1'b0;
    wait_until(n + 13);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    wait_until(n + 17);
    tick();

    // Asynchronous reset between edges while a load is pending
    c = cyc; load = 1'b1; value = 16'hFFFF; lz_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    expect_at(c, BL, BL, BL, BL, 4'hF, 1'b0, "rst_async_load");
    ->chk_ev;
    expect_at(c + 1, BL, BL, BL, BL, 4'hF, 1'b0, "rst_hold");
    expect_at(c + 2, BL, BL, BL, S0, 4'hF, 1'b0, "rst_release");
    expect_at(c + 3, BL, BL, BL, S0, 4'hF, 1'b0, "rst_no_capture");
    tick();
    rst_n = 1'b1; load = 1'b0;
    tick(); tick();

    budget = 0;
    while (sbq.size() > 0 && budget < 20) begin
      tick();
      budget++;
    end
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s timeout: due cyc %0d, still pending at cyc %0d", e.name, e.cyc, cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
